// File: rtl/user_gpio_pkg.sv
// Shared definitions for the user GPIO controller: register offsets,
// bus handshake states and the byte-strobe expansion helper.
package user_gpio_pkg;

  localparam logic [31:0] GPIO_OUT_OFS      = 32'h00;
  localparam logic [31:0] GPIO_OEN_OFS      = 32'h04;
  localparam logic [31:0] GPIO_IN_OFS       = 32'h08;
  localparam logic [31:0] GPIO_OUT_SET_OFS  = 32'h0C;
  localparam logic [31:0] GPIO_OUT_CLR_OFS  = 32'h10;
  localparam logic [31:0] GPIO_OUT_TGL_OFS  = 32'h14;
  localparam logic [31:0] GPIO_IRQ_EN_OFS   = 32'h18;
  localparam logic [31:0] GPIO_IRQ_TYPE_OFS = 32'h1C;
  localparam logic [31:0] GPIO_IRQ_POL_OFS  = 32'h20;
  localparam logic [31:0] GPIO_IRQ_STAT_OFS = 32'h24;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Expands the four byte strobes into a 32-bit bit-enable mask.
  function automatic logic [31:0] apply_strobe(input logic [3:0] wstrb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{wstrb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/user_gpio_sync_edge.sv
// Two-flop synchroniser plus a history flop for a vector of asynchronous pins;
// reports the synchronised level and single-cycle rise/fall indications.
module user_gpio_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;

  always_comb begin
    s1_d = pin_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/user_gpio_ctrl.sv
// Register-mapped user GPIO controller: native valid/ready bus slave driving
// the GPIO output/enable vectors and a combined per-pin level/edge interrupt.
`ifndef USER_GPIO_NUM
`define USER_GPIO_NUM 16
`endif

module user_gpio_ctrl
  import user_gpio_pkg::*;
#(
  parameter int GPIO_NUM = `USER_GPIO_NUM,
  parameter int ADDR_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic [31:0]         mem_rdata_o,
  output logic                mem_ready_o,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_oen_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic                irq_o
);

  bus_state_e          state_q, state_d;
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;
  logic [GPIO_NUM-1:0] out_q, out_d;
  logic [GPIO_NUM-1:0] oen_q, oen_d;
  logic [GPIO_NUM-1:0] irq_en_q, irq_en_d;
  logic [GPIO_NUM-1:0] irq_type_q, irq_type_d;
  logic [GPIO_NUM-1:0] irq_pol_q, irq_pol_d;
  logic [GPIO_NUM-1:0] edge_stat_q, edge_stat_d;

  logic [GPIO_NUM-1:0] pin_sync, pin_rise, pin_fall;
  logic                accept, wr_en;
  logic [31:0]         addr_ofs, wmask, wbits, rd_val;
  logic [GPIO_NUM-1:0] wmask_g, wbits_g, stat_clr, edge_hit, level_hit, irq_stat;
  logic                unused_hi;

  user_gpio_sync_edge #(
    .WIDTH (GPIO_NUM)
  ) u_sync_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (gpio_in_i),
    .sync_o (pin_sync),
    .rise_o (pin_rise),
    .fall_o (pin_fall)
  );

  // Request decode; bits above GPIO_NUM are dropped when slicing to the pin width.
  always_comb begin
    accept   = (state_q == BUS_IDLE) && mem_valid_i;
    wr_en    = accept && (mem_wstrb_i != 4'b0000);
    addr_ofs = 32'(mem_addr_i) & ~32'h3;
    wmask    = apply_strobe(mem_wstrb_i);
    wbits    = mem_wdata_i & wmask;
    wmask_g  = wmask[GPIO_NUM-1:0];
    wbits_g  = wbits[GPIO_NUM-1:0];
  end

  assign unused_hi = ^{wmask, wbits};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (mem_valid_i) begin
          state_d = BUS_ACK;
          ready_d = 1'b1;
        end
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    oen_d      = oen_q;
    irq_en_d   = irq_en_q;
    irq_type_d = irq_type_q;
    irq_pol_d  = irq_pol_q;
    stat_clr   = '0;
    if (wr_en) begin
      case (addr_ofs)
        GPIO_OUT_OFS:      out_d      = (out_q & ~wmask_g) | wbits_g;
        GPIO_OEN_OFS:      oen_d      = (oen_q & ~wmask_g) | wbits_g;
        GPIO_OUT_SET_OFS:  out_d      = out_q | wbits_g;
        GPIO_OUT_CLR_OFS:  out_d      = out_q & ~wbits_g;
        GPIO_OUT_TGL_OFS:  out_d      = out_q ^ wbits_g;
        GPIO_IRQ_EN_OFS:   irq_en_d   = (irq_en_q & ~wmask_g) | wbits_g;
        GPIO_IRQ_TYPE_OFS: irq_type_d = (irq_type_q & ~wmask_g) | wbits_g;
        GPIO_IRQ_POL_OFS:  irq_pol_d  = (irq_pol_q & ~wmask_g) | wbits_g;
        GPIO_IRQ_STAT_OFS: stat_clr   = wbits_g;
        default: ;
      endcase
    end
  end

  // A fresh edge overrides a same-cycle clear; masking with the new type
  // drops sticky bits on pins being switched to level mode.
  always_comb begin
    edge_hit    = (irq_pol_q & pin_rise) | (~irq_pol_q & pin_fall);
    edge_stat_d = ((edge_stat_q & ~stat_clr) | edge_hit) & irq_type_d;
    level_hit   = ~(pin_sync ^ irq_pol_q);
    irq_stat    = (irq_type_q & edge_stat_q) | (~irq_type_q & level_hit);
    irq_d       = |(irq_stat & irq_en_q);
  end

  always_comb begin
    rd_val = 32'h0;
    case (addr_ofs)
      GPIO_OUT_OFS:      rd_val = 32'(out_q);
      GPIO_OEN_OFS:      rd_val = 32'(oen_q);
      GPIO_IN_OFS:       rd_val = 32'(pin_sync);
      GPIO_IRQ_EN_OFS:   rd_val = 32'(irq_en_q);
      GPIO_IRQ_TYPE_OFS: rd_val = 32'(irq_type_q);
      GPIO_IRQ_POL_OFS:  rd_val = 32'(irq_pol_q);
      GPIO_IRQ_STAT_OFS: rd_val = 32'(irq_stat);
      default:           rd_val = 32'h0;
    endcase
    rdata_d = accept ? rd_val : 32'h0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BUS_IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      irq_q       <= 1'b0;
      out_q       <= '0;
      oen_q       <= '1;
      irq_en_q    <= '0;
      irq_type_q  <= '0;
      irq_pol_q   <= '0;
      edge_stat_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      out_q       <= out_d;
      oen_q       <= oen_d;
      irq_en_q    <= irq_en_d;
      irq_type_q  <= irq_type_d;
      irq_pol_q   <= irq_pol_d;
      edge_stat_q <= edge_stat_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign gpio_out_o  = out_q;
  assign gpio_oen_o  = oen_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/user_gpio_ctrl.md
Name: user_gpio_ctrl

Overview:
- Register-mapped controller that owns and sequences the user GPIO bank.
- Drives the output and output-enable vectors, synchronises the input vector, and detects per-pin level/edge interrupts.
- Sits between the SoC native memory bus (valid/ready, picorv32 style) and the user GPIO interface (dut modport: gpio_out, gpio_in, gpio_oen).
- Produces one combined interrupt line to the SoC IRQ controller.

Parameters:
- GPIO_NUM, default `USER_GPIO_NUM (header default 16, legal range 1..32): number of GPIO pins.
- ADDR_W, default 8: byte-address bits decoded from mem_addr_i.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- mem_valid_i  in  1  bus request; held high until mem_ready_o
- mem_addr_i  in  ADDR_W  byte address, word aligned, bits[1:0] ignored
- mem_wdata_i  in  32  write data
- mem_wstrb_i  in  4  byte strobes; all zero means a read
- mem_rdata_o  out  32  read data, valid when mem_ready_o is high
- mem_ready_o  out  1  one-cycle completion pulse
- gpio_out_o  out  GPIO_NUM  to user_gpio_if.gpio_out
- gpio_oen_o  out  GPIO_NUM  to user_gpio_if.gpio_oen; active-low output enable
- gpio_in_i  in  GPIO_NUM  from user_gpio_if.gpio_in; asynchronous to clk_i
- irq_o  out  1  OR of (IRQ_STAT & IRQ_EN), registered

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - OUT = 0
  - OEN = all 1s (all pins are inputs)
  - IRQ_EN = 0, IRQ_TYPE = 0, IRQ_POL = 0
  - edge-status flops = 0, sync/history flops = 0
  - mem_ready_o = 0, mem_rdata_o = 0, irq_o = 0
- Bus FSM:
  - Two states, IDLE and ACK.
  - IDLE + mem_valid_i -> ACK. On this edge, register mem_ready_o=1, perform the write, and register mem_rdata_o.
  - ACK -> IDLE unconditionally, with mem_ready_o=0.
  - Latency is one cycle. Maximum rate is one transaction per two cycles.
  - If valid stays high across an ACK, the next transaction is accepted in the following IDLE cycle, never in ACK.
  - When mem_ready_o is low, mem_rdata_o returns to 0.
- Register map (word offsets):
  - 0x00 OUT: RW
  - 0x04 OEN: RW
  - 0x08 IN: RO, synchronised input
  - 0x0C OUT_SET: W1S on OUT, reads 0
  - 0x10 OUT_CLR: W1C on OUT, reads 0
  - 0x14 OUT_TGL: write-1-toggle on OUT, reads 0
  - 0x18 IRQ_EN: RW
  - 0x1C IRQ_TYPE: RW; 0 = level, 1 = edge
  - 0x20 IRQ_POL: RW; 0 = low/falling, 1 = high/rising
  - 0x24 IRQ_STAT: read status; write-1-clear for edge pins
- Byte strobes: every write is masked per byte by mem_wstrb_i. This includes SET/CLR/TGL/W1C.
- Unused bits and unmapped addresses:
  - Bits at or above GPIO_NUM read 0 and ignore writes.
  - Unmapped addresses read 0, writes are ignored, and the access is still acknowledged.
- Output timing: gpio_out_o and gpio_oen_o come straight from registers. They change on the same edge that raises mem_ready_o.
- Input path:
  - Two-flop synchroniser gives s2; a third history flop gives s3.
  - IN reads s2.
  - Pin edge to IN visibility is 2-3 cycles.
- Interrupt status:
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edge pins: the stat bit sets on the selected edge and is sticky until W1C.
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
  - Level pins: the stat bit equals (s2 == IRQ_POL) live. W1C has no effect.
  - Changing IRQ_TYPE from edge to level discards the sticky bit.
- irq_o: registered, so it is one cycle after the stat update.
- Reset mid-transaction: the FSM returns to IDLE, mem_ready_o=0, and the pending write is dropped. The master retries.

Decomposition:
- Package user_gpio_pkg holds:
  - register offset localparams (GPIO_OUT_OFS..GPIO_IRQ_STAT_OFS)
  - enum typedef for bus states {BUS_IDLE, BUS_ACK}
  - an apply-strobe function that expands wstrb into a 32-bit mask
- One sub-module, user_gpio_sync_edge: GPIO_NUM-wide 2-flop sync, history flop, and rise/fall outputs. It is reusable by other pin-facing blocks.

Test Plan:
- Reset with GPIO_NUM=16 -> gpio_oen_o=16'hFFFF, gpio_out_o=0, irq_o=0. All register reads return 0, except OEN which reads 32'h0000FFFF.
- Write OUT=32'h1234_A5A5 with wstrb=4'b0001 -> gpio_out_o=16'h00A5 on the ready edge, with mem_ready_o high for exactly 1 cycle. Then SET 0x0F00 -> 16'h0FA5, CLR 0x0005 -> 16'h0FA0, TGL 0xFFFF -> 16'hF05F.
- Hold mem_valid_i high for 5 cycles over two reads of 0x00 and 0x08 -> mem_ready_o pattern is 0,1,0,1. gpio_in_i=16'h8001 is read as 32'h0000_8001 when the pin change happens ≥3 cycles before the request.
- Pin 3 edge/rising, IRQ_EN=0x8, pulse gpio_in_i[3] for 1 cycle -> IRQ_STAT=0x8 and irq_o high, held after the pin falls. W1C 0x8 -> irq_o low 1 cycle after. A second rising edge in the same cycle as the W1C -> bit stays set.
- Pin 0 level/low, IRQ_EN=1, gpio_in_i[0]=0 -> irq_o=1. W1C has no effect. gpio_in_i[0]=1 -> irq_o=0 within 4 cycles.
- Access to unmapped 0x40 -> acknowledged, rdata=0, no state change. Assert rst_i during ACK -> next cycle mem_ready_o=0 and all registers are at reset values.
